// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter.
package data_ram_arbiter_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int MASK_WIDTH         = DATA_WIDTH_DEFAULT / 8;

  // Arbiter sequencing states; only IDLE samples new requests.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    CAPTURE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  // Identity of the requester currently (or last) granted.
  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_CORE = 1'b1
  } grant_t;

endpackage

// File: rtl/data_ram_rr_pick.sv
// Two-way requester pick: fixed host priority or alternate-on-tie.
module data_ram_rr_pick
  import data_ram_arbiter_pkg::*;
#(
  parameter int HOST_PRIORITY = 0
) (
  input  logic   host_req,
  input  logic   core_req,
  input  grant_t last_grant,
  output grant_t winner
);

  // Pick the winner; a lone requester always wins, ties go by policy.
  always_comb begin
    // NOTE: default assigned first so every path drives winner and no latch is inferred.
    winner = GRANT_HOST;
    if (core_req && !host_req) begin
      winner = GRANT_CORE;
    end else if (core_req && host_req && (HOST_PRIORITY == 0) &&
                 (last_grant == GRANT_HOST)) begin
      winner = GRANT_CORE;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one synchronous data BlockRam between the host port and the core
// load/store path; partial-word stores become read-modify-write sequences.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int HOST_PRIORITY = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    host_req,
  input  logic                    host_write,
  input  logic [ADDR_WIDTH-1:0]   host_address,
  input  logic [DATA_WIDTH-1:0]   host_wdata,
  input  logic [DATA_WIDTH/8-1:0] host_mask,
  output logic                    host_ack,
  output logic [DATA_WIDTH-1:0]   host_rdata,
  input  logic                    core_req,
  input  logic                    core_write,
  input  logic [ADDR_WIDTH-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_mask,
  output logic                    core_ack,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic                    ram_write,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic                    busy
);

  localparam int MW = DATA_WIDTH / 8;

  state_t                  state;
  state_t                  state_next;
  grant_t                  last_grant;
  grant_t                  lat_grant;
  grant_t                  winner;
  logic                    lat_write;
  logic [ADDR_WIDTH-3:0]   lat_word;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [MW-1:0]           lat_mask;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   merged_next;
  logic                    mask_full;
  logic                    mask_empty;
  logic                    mask_partial;
  logic                    finish;

  assign mask_full    = &lat_mask;
  assign mask_empty   = ~|lat_mask;
  assign mask_partial = !mask_full && !mask_empty;

  data_ram_rr_pick #(
    .HOST_PRIORITY (HOST_PRIORITY)
  ) u_pick (
    .host_req   (host_req),
    .core_req   (core_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // Outputs decoded from state so reset drops ram_write in the same cycle.
  assign ram_write      = ((state == ACCESS) && lat_write && mask_full) ||
                          (state == WRITEBACK);
  assign ram_write_data = (state == WRITEBACK) ? merged : lat_wdata;
  assign ram_address    = {2'b00, lat_word};
  assign busy           = (state != IDLE);

  // Cycle in which the granted access completes; its ack fires next cycle.
  assign finish = ((state == ACCESS) && lat_write && !mask_partial) ||
                  ((state == CAPTURE) && !lat_write) ||
                  (state == WRITEBACK);

  // Byte-lane merge of store data over the word just read back.
  always_comb begin
    merged_next = ram_read_data;
    for (int i = 0; i < MW; i++) begin
      if (lat_mask[i]) begin
        merged_next[8*i +: 8] = lat_wdata[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      state <= state_next;
    end
  end

  // Next-state sequencing; requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (host_req || core_req) state_next = ACCESS;
      ACCESS:    state_next = (!lat_write || mask_partial) ? CAPTURE : IDLE;
      CAPTURE:   state_next = lat_write ? WRITEBACK : IDLE;
      WRITEBACK: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Grant latching, read-data capture, merge register and ack pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every datapath register is reset so a mid-access reset leaves clean outputs.
      last_grant <= GRANT_HOST;
      lat_grant  <= GRANT_HOST;
      lat_write  <= 1'b0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
      merged     <= '0;
      host_ack   <= 1'b0;
      core_ack   <= 1'b0;
      host_rdata <= '0;
      core_rdata <= '0;
    end else begin
      host_ack <= finish && (lat_grant == GRANT_HOST);
      core_ack <= finish && (lat_grant == GRANT_CORE);
      case (state)
        IDLE: begin
          if (host_req || core_req) begin
            last_grant <= winner;
            lat_grant  <= winner;
            if (winner == GRANT_HOST) begin
              lat_write <= host_write;
              lat_word  <= host_address[ADDR_WIDTH-1:2];
              lat_wdata <= host_wdata;
              lat_mask  <= host_mask;
            end else begin
              lat_write <= core_write;
              lat_word  <= core_address[ADDR_WIDTH-1:2];
              lat_wdata <= core_wdata;
              lat_mask  <= core_mask;
            end
          end
        end
        CAPTURE: begin
          if (!lat_write) begin
            if (lat_grant == GRANT_HOST) host_rdata <= ram_read_data;
            else                         core_rdata <= ram_read_data;
          end else begin
            merged <= merged_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: round-robin instance plus a
// host-priority instance, each with its own behavioural BlockRam.
module tb_data_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        host_req, host_write, core_req, core_write;
  logic [15:0] host_address, core_address;
  logic [31:0] host_wdata, core_wdata;
  logic [3:0]  host_mask, core_mask;
  logic        host_ack, core_ack, ram_write, busy;
  logic [31:0] host_rdata, core_rdata, ram_write_data, ram_read_data;
  logic [15:0] ram_address;

  logic        p_host_req, p_core_req;
  logic        p_host_ack, p_core_ack, p_ram_write, p_busy;
  logic [31:0] p_host_rdata, p_core_rdata, p_ram_write_data, p_ram_read_data;
  logic [15:0] p_ram_address;

  logic [31:0] mem   [0:16383];
  logic [31:0] p_mem [0:16383];

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int host_ack_count = 0;

  always #5 clock = ~clock;

  data_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .HOST_PRIORITY(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_req(host_req), .host_write(host_write), .host_address(host_address),
    .host_wdata(host_wdata), .host_mask(host_mask), .host_ack(host_ack),
    .host_rdata(host_rdata),
    .core_req(core_req), .core_write(core_write), .core_address(core_address),
    .core_wdata(core_wdata), .core_mask(core_mask), .core_ack(core_ack),
    .core_rdata(core_rdata),
    .ram_address(ram_address), .ram_write(ram_write),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .busy(busy)
  );

  data_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .HOST_PRIORITY(1)) dut_p (
    .clock(clock), .reset_n(reset_n),
    .host_req(p_host_req), .host_write(1'b0), .host_address(16'h0004),
    .host_wdata(32'h0), .host_mask(4'h0), .host_ack(p_host_ack),
    .host_rdata(p_host_rdata),
    .core_req(p_core_req), .core_write(1'b0), .core_address(16'h0008),
    .core_wdata(32'h0), .core_mask(4'h0), .core_ack(p_core_ack),
    .core_rdata(p_core_rdata),
    .ram_address(p_ram_address), .ram_write(p_ram_write),
    .ram_write_data(p_ram_write_data), .ram_read_data(p_ram_read_data), .busy(p_busy)
  );

  // Synchronous-read RAM models and event counters.
  always @(posedge clock) begin
    if (ram_write) mem[ram_address[13:0]] <= ram_write_data;
    ram_read_data <= mem[ram_address[13:0]];
    if (p_ram_write) p_mem[p_ram_address[13:0]] <= p_ram_write_data;
    p_ram_read_data <= p_mem[p_ram_address[13:0]];
    if (ram_write) wr_count <= wr_count + 1;
    if (host_ack) host_ack_count <= host_ack_count + 1;
  end

  typedef struct {
    bit          is_host;
    bit          write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_writes;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One access on one port; lat is the ack cycle relative to the grant cycle.
  task automatic do_access(input bit is_host, input bit w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           output int lat, output logic [31:0] rd);
    @(negedge clock);
    if (is_host) begin
      host_req = 1'b1; host_write = w; host_address = a; host_wdata = d; host_mask = m;
    end else begin
      core_req = 1'b1; core_write = w; core_address = a; core_wdata = d; core_mask = m;
    end
    @(posedge clock); #1;
    host_req = 1'b0;
    core_req = 1'b0;
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (is_host ? host_ack : core_ack) begin
        lat = k + 1;
        rd  = is_host ? host_rdata : core_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          w0;
    int          a0;
    int          n;
    logic [31:0] rd;
    int          ev_cyc  [4];
    bit          ev_core [4];
    logic [31:0] ev_data [4];

    for (int i = 0; i < 16384; i++) begin
      mem[i]   = '0;
      p_mem[i] = '0;
    end
    p_mem[1] = 32'h1111_0001;
    p_mem[2] = 32'h2222_0002;

    host_req = 0; host_write = 0; host_address = '0; host_wdata = '0; host_mask = '0;
    core_req = 0; core_write = 0; core_address = '0; core_wdata = '0; core_mask = '0;
    p_host_req = 0; p_core_req = 0;

    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 32'h0,         4'h0, 3, 32'hDEADBEEF, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0020, 32'h11223344, 4'hF, 2, 32'h0,        1};
    vecs[2]  = '{1'b0, 1'b1, 16'h0020, 32'h000000AA, 4'h1, 4, 32'h0,        1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0020, 32'h0,         4'h0, 3, 32'h112233AA, 0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0020, 32'h55660000, 4'hC, 4, 32'h0,        1};
    vecs[5]  = '{1'b1, 1'b0, 16'h0020, 32'h0,         4'h0, 3, 32'h556633AA, 0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0, 2, 32'h0,        0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0020, 32'h0,         4'h0, 3, 32'h556633AA, 0};
    vecs[8]  = '{1'b1, 1'b1, 16'hFFFC, 32'hCAFEF00D, 4'hF, 2, 32'h0,        1};
    vecs[9]  = '{1'b0, 1'b0, 16'hFFFE, 32'h0,         4'h0, 3, 32'hCAFEF00D, 0};
    vecs[10] = '{1'b1, 1'b1, 16'h0000, 32'h00BB0000, 4'h4, 4, 32'h0,        1};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 32'h0,         4'h0, 3, 32'h00BB0000, 0};

    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_host_ack", {31'b0, host_ack}, 32'h0);
    check("rst_core_ack", {31'b0, core_ack}, 32'h0);
    check("rst_ram_write", {31'b0, ram_write}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ram_address", {16'h0, ram_address}, 32'h0);
    check("rst_ram_write_data", ram_write_data, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Full-word host store: write strobe in T+1, ack in T+2.
    @(negedge clock);
    host_req = 1'b1; host_write = 1'b1; host_address = 16'h0010;
    host_wdata = 32'hDEADBEEF; host_mask = 4'hF;
    @(posedge clock); #1;
    host_req = 1'b0;
    check("t1_ram_write", {31'b0, ram_write}, 32'h1);
    check("t1_ram_address", {16'h0, ram_address}, 32'h4);
    check("t1_ram_write_data", ram_write_data, 32'hDEADBEEF);
    check("t1_ack_not_early", {31'b0, host_ack}, 32'h0);
    @(posedge clock); #1;
    check("t1_host_ack", {31'b0, host_ack}, 32'h1);
    check("t1_idle_in_ack", {31'b0, busy}, 32'h0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      w0 = wr_count;
      do_access(vecs[i].is_host, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                vecs[i].mask, lat, rd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_ram_writes", i), wr_count - w0, vecs[i].exp_writes);
      if (!vecs[i].write) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    check("wrap_word_3fff", mem[16'h3FFF], 32'hCAFEF00D);
    check("core_rdata_held", core_rdata, 32'hCAFEF00D);

    // Round-robin contention after reset: core, host, core, host.
    apply_reset();
    @(negedge clock);
    host_req = 1'b1; host_write = 1'b0; host_address = 16'h0010;
    core_req = 1'b1; core_write = 1'b0; core_address = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      ev_cyc[i] = -1; ev_core[i] = 1'b0; ev_data[i] = '0;
    end
    n = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(posedge clock); #1;
      if (host_ack || core_ack) begin
        ev_cyc[n]  = c;
        ev_core[n] = core_ack;
        ev_data[n] = core_ack ? core_rdata : host_rdata;
        n++;
        if (n == 4) begin
          host_req = 1'b0;
          core_req = 1'b0;
        end
      end
    end
    host_req = 1'b0;
    core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr%0d_cycle", i), ev_cyc[i], 3 * (i + 1));
      check($sformatf("rr%0d_is_core", i), {31'b0, ev_core[i]}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr%0d_rdata", i), ev_data[i], (i % 2 == 0) ? 32'h556633AA : 32'hDEADBEEF);
    end

    // Host-priority instance: host wins while it holds req, then core.
    @(negedge clock);
    p_host_req = 1'b1;
    p_core_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_cyc[i] = -1; ev_core[i] = 1'b0; ev_data[i] = '0;
    end
    n = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(posedge clock); #1;
      if (p_host_ack || p_core_ack) begin
        ev_cyc[n]  = c;
        ev_core[n] = p_core_ack;
        ev_data[n] = p_core_ack ? p_core_rdata : p_host_rdata;
        n++;
        if (n == 3) p_host_req = 1'b0;
        if (n == 4) p_core_req = 1'b0;
      end
    end
    p_host_req = 1'b0;
    p_core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hp%0d_cycle", i), ev_cyc[i], 3 * (i + 1));
      check($sformatf("hp%0d_is_core", i), {31'b0, ev_core[i]}, (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("hp%0d_rdata", i), ev_data[i], (i == 3) ? 32'h2222_0002 : 32'h1111_0001);
    end

    // Reset during CAPTURE of a partial store.
    @(negedge clock);
    host_req = 1'b1; host_write = 1'b1; host_address = 16'h0030;
    host_wdata = 32'hAAAABBBB; host_mask = 4'h3;
    @(posedge clock); #1;
    host_req = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_busy_before", {31'b0, busy}, 32'h1);
    w0 = wr_count;
    a0 = host_ack_count;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ram_write", {31'b0, ram_write}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_ram_address", {16'h0, ram_address}, 32'h0);
    check("mid_rst_ram_write_data", ram_write_data, 32'h0);
    check("mid_rst_host_rdata", host_rdata, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("mid_rst_no_write", wr_count - w0, 32'h0);
    check("mid_rst_no_ack", host_ack_count - a0, 32'h0);
    check("mid_rst_mem_intact", mem[12], 32'h0);
    do_access(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, lat, rd);
    check("post_rst_load_latency", lat, 32'd3);
    check("post_rst_load_rdata", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
Shares the single data BlockRam (one-cycle synchronous read, synchronous write, word-addressed) between two requesters: the host/external port and the core load/store path.
It serialises accesses, returns read data, and turns partial-word stores into read-modify-write sequences.
It sits between the core top level and the dataRam instance and replaces the direct external hookup.

Parameters:
ADDR_WIDTH, 16, byte-address width of both requester ports and the RAM address.
DATA_WIDTH, 32, word width; byte-mask width is DATA_WIDTH/8.
HOST_PRIORITY, 0, 0 = round-robin between host and core; 1 = host strictly wins when both request.

Ports:
clock  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
host_req  in  1  host request; held until host_ack.
host_write  in  1  1 = store, 0 = load.
host_address  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
host_wdata  in  DATA_WIDTH  store data, byte lanes little-endian.
host_mask  in  DATA_WIDTH/8  store byte enables; ignored for loads.
host_ack  out  1  one-cycle completion pulse.
host_rdata  out  DATA_WIDTH  load data; valid in the host_ack cycle, held until the next load completes.
core_req, core_write, core_address, core_wdata, core_mask, core_ack, core_rdata  same widths and meanings as the host_* ports, for the core.
ram_address  out  ADDR_WIDTH  word address to the RAM: zero-extended address[ADDR_WIDTH-1:2]; drives both the read and write address.
ram_write  out  1  RAM write enable.
ram_write_data  out  DATA_WIDTH  RAM write data.
ram_read_data  in  DATA_WIDTH  RAM read data; valid one cycle after the address is presented.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and reset_n is active-low.
  - Reset values: state = IDLE; host_ack, core_ack and ram_write = 0; host_rdata, core_rdata, ram_address and ram_write_data = 0; last_grant = HOST.
- Reset mid-operation: the access is abandoned, no ack is ever issued for it, and ram_write is low in the reset cycle.
- ram_write must be decoded from state so that reset forces it low immediately.
- States: IDLE, ACCESS, CAPTURE, WRITEBACK. All ack outputs are registered one-cycle pulses.
- IDLE:
  - If either req is high, choose a winner, latch its write/address/wdata/mask and the grant, then go to ACCESS.
  - Arbitration: HOST_PRIORITY=1 → host wins ties. HOST_PRIORITY=0 → the requester not granted last wins ties (after reset the core wins the first tie).
  - A single requester always wins.
  - last_grant updates on every grant.
- ACCESS: ram_address = latched word address.
  - Load, or store with mask neither all-ones nor all-zeros → CAPTURE.
  - Store with mask all-ones → ram_write=1 with ram_write_data=wdata, ack, → IDLE.
  - Store with mask all-zeros → no RAM write, ack, → IDLE.
- CAPTURE: ram_read_data is valid in this state.
  - Load: winner's rdata <= ram_read_data, ack, → IDLE.
  - Partial store: merged <= per byte, mask ? wdata : ram_read_data; → WRITEBACK.
- WRITEBACK: ram_write=1 with ram_write_data=merged at the latched address, ack, → IDLE.
- Latency, with req first seen in IDLE at cycle T:
  - full or empty-mask store: ack at T+2.
  - load: ack and rdata at T+3.
  - partial store: ack at T+4.
- Requests are not re-sampled during ACCESS, CAPTURE or WRITEBACK. The loser's req stays pending and is served next.
- The ack cycle is an IDLE cycle. A req still high in the ack cycle is a new back-to-back request.
  - Requesters must drop req in the ack cycle unless they intend a new access.
- The non-winning requester's ack and rdata are unchanged during the other requester's access.
- Address wrap: ram_address covers the full word range with no bounds check. Address 0xFFFC maps to word 0x3FFF.
- Only one access is outstanding at a time, so there are no read/write hazards.

Decomposition:
- Shared package: state encoding localparams (IDLE, ACCESS, CAPTURE, WRITEBACK), grant IDs (GRANT_HOST, GRANT_CORE), and the MASK_WIDTH = DATA_WIDTH/8 constant.
- One natural sub-module: data_ram_rr_pick, a combinational two-way pick from the two req bits, last_grant and HOST_PRIORITY, returning the winner ID.
- Merge logic and the FSM stay inline.

Test Plan:
1. Host store 0xDEADBEEF to 0x0010 with mask 0xF at T:
   - ram_write=1 at T+1 with ram_address 0x0004; host_ack at T+2.
   - A host load of 0x0010 then returns host_rdata 0xDEADBEEF at ack, T+3 relative to that load.
2. Word 0x0020 = 0x11223344; core store 0x000000AA with mask 0x1:
   - core_ack at T+4; a subsequent load returns 0x112233AA.
   - Repeat with mask 0xC and wdata 0x55660000 → 0x556633AA.
3. HOST_PRIORITY=0, both req held high continuously with loads:
   - Grants alternate core, host, core, host (core first after reset).
   - Each ack arrives 3 cycles after its grant cycle; no starvation.
4. HOST_PRIORITY=1, both req high: host served on every grant while host_req stays high; core is served only once host drops req.
5. Store with mask 0x0: no ram_write pulse, ack at T+2, and a subsequent load shows memory unchanged.
6. Assert reset_n low during CAPTURE of a partial store:
   - ram_write never pulses and no ack is issued; outputs return to their reset values.
   - After release, a new host load completes normally at T+3.
